seq_mul: RTL and testbench

// - Parametrised iterative shift-add multiplier: WIDTH_A x WIDTH_B -> WIDTH_A+WIDTH_B product, one multiplier bit per clock.
// - Sits beside the datapath as a low-area multiply unit with START/BUSY/DONE handshake; result register holds until next job.
// - Optional two's-complement mode selectable per operation.
//

---
 rtl/seq_mul.sv | 131 +++++++++++++
 tb/tb_seq_mul.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// ============================================================================
//  Module      : seq_mul
//  Description : Iterative shift-add multiplier, one multiplier bit per clock,
//                with START/BUSY/DONE handshake. Y holds until the next job
//                completes. Defining SEQ_MUL_SIGNED_EN adds the SGN port and
//                per-operation two's-complement mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [WIDTH_A-1:0]         A,
  input  logic [WIDTH_B-1:0]         B,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic                       SGN,
`endif
  output logic                       BUSY,
  output logic                       DONE,
  output logic [WIDTH_A+WIDTH_B-1:0] Y
);

  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int CW = $clog2(WIDTH_B + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_a;
  logic [WIDTH_B-1:0] r_b;
  logic [PW-1:0]   r_p;
  logic [PW-1:0]   r_y;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic [PW-1:0]   w_sum;
  logic [PW-1:0]   w_a_ext;
  logic            w_accept;
  logic            w_last;
`ifdef SEQ_MUL_SIGNED_EN
  logic            r_sgn;
`endif

  // START is only honoured when no job is running (DONE cycle counts as idle)
  assign w_accept = (r_state == S_IDLE) && START;
  // remaining count of one means this edge consumes the top multiplier bit
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

`ifdef SEQ_MUL_SIGNED_EN
  assign w_a_ext = {{WIDTH_B{A[WIDTH_A-1] & SGN}}, A};
`else
  assign w_a_ext = {{WIDTH_B{1'b0}}, A};
`endif

  assign BUSY = (r_state == S_RUN);
  assign DONE = r_done;
  assign Y    = r_y;

  // partial-product step; the signed top bit carries negative weight
  always_comb begin
    w_sum = r_p;
    if (r_b[0]) begin
`ifdef SEQ_MUL_SIGNED_EN
      if (r_sgn && w_last) w_sum = r_p - r_a;
      else                 w_sum = r_p + r_a;
`else
      w_sum = r_p + r_a;
`endif
    end
  end

  // control state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // operand load, shift-add iteration and result capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      r_sgn  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a    <= w_a_ext;
      r_b    <= B;
      r_p    <= '0;
      r_cnt  <= CW'(WIDTH_B);
      r_done <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      r_sgn  <= SGN;
`endif
    end else if (r_state == S_RUN) begin
      r_p    <= w_sum;
      r_a    <= r_a << 1;
      r_b    <= r_b >> 1;
      r_cnt  <= r_cnt - CW'(1);
      r_done <= w_last;
      if (w_last) r_y <= w_sum;
    end else begin
      r_done <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_mul.sv
// ============================================================================
//  Module      : tb_seq_mul
//  Description : Directed self-checking bench for seq_mul (8x8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        SGN;
  logic        BUSY;
  logic        DONE;
  logic [15:0] Y;

  int total = 0;
  int bad   = 0;
  int n;
  int seen_done;

  seq_mul #(.WIDTH_A(8), .WIDTH_B(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
`ifdef SEQ_MUL_SIGNED_EN
    .SGN   (SGN),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Y     (Y)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // issue one START pulse; returns at the negedge after the accepting edge
  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge CLK);
    START = 1'b1; A = a; B = b; SGN = s;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // bounded wait for DONE, then check latency and product
  task automatic wait_done(input string tag, input logic [15:0] exp_y);
    n = 0;
    while (!DONE && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_y"}, {16'h0, Y}, {16'h0, exp_y});
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0; SGN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'h0, BUSY}, 0);
    chk("rst_y", {16'h0, Y}, 0);
    RST = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("idle_busy", {31'h0, BUSY}, 0);
      chk("idle_done", {31'h0, DONE}, 0);
      chk("idle_y", {16'h0, Y}, 0);
    end

    // 0xFF * 0xFF, cycle-accurate BUSY window
    go(8'hFF, 8'hFF, 1'b0);
    chk("ff_busy1", {31'h0, BUSY}, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      chk("ff_busy", {31'h0, BUSY}, 1);
      chk("ff_nodone", {31'h0, DONE}, 0);
    end
    @(negedge CLK);
    chk("ff_done", {31'h0, DONE}, 1);
    chk("ff_idle", {31'h0, BUSY}, 0);
    chk("ff_y", {16'h0, Y}, 32'hFE01);
    @(negedge CLK);
    chk("ff_done_clr", {31'h0, DONE}, 0);
    chk("ff_y_hold", {16'h0, Y}, 32'hFE01);

    // START while busy is ignored
    go(8'h03, 8'h05, 1'b0);
    START = 1'b1; A = 8'h00; B = 8'h00;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      if (i == 3) START = 1'b0;
    end
    START = 1'b0;
    @(negedge CLK);
    chk("ign_done", {31'h0, DONE}, 1);
    chk("ign_y", {16'h0, Y}, 32'h000F);

    // back-to-back: new START in the DONE cycle
    go(8'h07, 8'h09, 1'b0);
    wait_done("b2b_first", 16'h003F);
    START = 1'b1; A = 8'h10; B = 8'h10;
    @(negedge CLK);
    START = 1'b0;
    chk("b2b_busy", {31'h0, BUSY}, 1);
    chk("b2b_y_hold", {16'h0, Y}, 32'h003F);
    wait_done("b2b_second", 16'h0100);

    // assorted unsigned products and zero operands
    go(8'hAB, 8'hCD, 1'b0);  wait_done("u_abcd", 16'h88EF);
    go(8'h00, 8'hAB, 1'b0);  wait_done("u_zero_a", 16'h0000);
    go(8'h5A, 8'h00, 1'b0);  wait_done("u_zero_b", 16'h0000);
    go(8'hFF, 8'h02, 1'b0);  wait_done("u_ff02", 16'h01FE);

`ifdef SEQ_MUL_SIGNED_EN
    go(8'hFF, 8'h02, 1'b1);  wait_done("s_ff02", 16'hFFFE);
    go(8'h80, 8'h80, 1'b1);  wait_done("s_8080", 16'h4000);
    go(8'hFF, 8'hFF, 1'b1);  wait_done("s_ffff", 16'h0001);
    go(8'hFF, 8'h02, 1'b0);  wait_done("s0_ff02", 16'h01FE);
`endif

    // asynchronous reset mid-run
    go(8'h0F, 8'h0F, 1'b0);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", {31'h0, BUSY}, 0);
    chk("arst_done", {31'h0, DONE}, 0);
    chk("arst_y", {16'h0, Y}, 0);
    @(negedge CLK);
    RST = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE) seen_done++;
    end
    chk("arst_no_done", seen_done, 0);
    chk("arst_idle", {31'h0, BUSY}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
